// File: rtl/seq_shift_pkg.sv
// seq_shift_pkg
// Shared definitions for the sequential shift unit: shift-mode encodings
// and the controller state type.
package seq_shift_pkg;

    // Shift modes carried on the Op port
    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// shift_step
// Combinational single-position shifter: produces the accumulator value
// after one step of the selected shift mode.
// Ports:
//   i_acc  [WIDTH-1:0]  current accumulator
//   i_op   [1:0]        shift mode (SRA/SRL/SLL/ROR)
//   o_next [WIDTH-1:0]  accumulator after one step
module shift_step
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_next
);

    always_comb begin
        o_next = i_acc;
        case (i_op)
            OP_SRA:  o_next = {i_acc[WIDTH-1], i_acc[WIDTH-1:1]};
            OP_SRL:  o_next = {1'b0, i_acc[WIDTH-1:1]};
            OP_SLL:  o_next = {i_acc[WIDTH-2:0], 1'b0};
            OP_ROR:  o_next = {i_acc[0], i_acc[WIDTH-1:1]};
            default: o_next = i_acc;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// seq_shift_unit
// Multi-cycle shift unit: on Start (in IDLE) loads the operand, mode and
// effective amount, then shifts one bit position per clock. The result is
// registered on completion and held until the next completion.
// Ports:
//   clk               system clock (rising edge)
//   rst               synchronous active-high reset
//   Start             request, sampled only in IDLE
//   Op     [1:0]      mode: 00 SRA, 01 SRL, 10 SLL, 11 ROR
//   Input1 [WIDTH-1:0] operand
//   Input2 [WIDTH-1:0] shift amount (unsigned)
//   Result [WIDTH-1:0] last completed result
//   Done              one-cycle completion pulse
//   Busy              high whenever the controller is not idle
module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Input1,
    input  logic [WIDTH-1:0] Input2,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             Busy
);

    localparam int               LOG_W     = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] AMT_LIMIT = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_busy;

    logic [CNT_W-1:0] w_eff;
    logic [WIDTH-1:0] w_next;

    // Rotation wraps modulo WIDTH; the linear shifts clamp at WIDTH, which
    // already yields all-sign-bits (SRA) or zero (SRL/SLL).
    always_comb begin
        if (Op == OP_ROR) begin
            w_eff = CNT_W'(Input2[LOG_W-1:0]);
        end else if (Input2 >= AMT_LIMIT) begin
            w_eff = CNT_MAX;
        end else begin
            w_eff = Input2[CNT_W-1:0];
        end
    end

    shift_step #(
        .WIDTH(WIDTH)
    ) u_shift_step (
        .i_acc  (r_acc),
        .i_op   (r_op),
        .o_next (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_op     <= OP_SRA;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_acc  <= Input1;
                        r_op   <= Op;
                        r_cnt  <= w_eff;
                        r_busy <= 1'b1;
                        if (w_eff == '0) begin
                            // Zero-length op: result is the operand itself
                            r_state  <= ST_DONE;
                            r_result <= Input1;
                            r_done   <= 1'b1;
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        // Capture the post-step value so Result never
                        // exposes intermediate accumulator contents
                        r_state  <= ST_DONE;
                        r_result <= w_next;
                        r_done   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Result = r_result;
    assign Done   = r_done;
    assign Busy   = r_busy;

endmodule

// File: tb/tb_seq_shift_unit.sv
module tb_seq_shift_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] Input1;
    logic [W-1:0] Input2;
    logic [W-1:0] Result;
    logic         Done;
    logic         Busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    seq_shift_unit #(
        .WIDTH(W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .Start  (Start),
        .Op     (Op),
        .Input1 (Input1),
        .Input2 (Input2),
        .Result (Result),
        .Done   (Done),
        .Busy   (Busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Effective amount: rotate wraps, linear shifts clamp at the width
    function automatic int eff_of(input logic [1:0] op, input logic [W-1:0] amt);
        int a;
        a = int'(amt);
        if (op == 2'b11) return a % W;
        return (a > W) ? W : a;
    endfunction

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] amt);
        int e;
        logic signed [W-1:0] sa;
        logic [W-1:0] r;
        e  = eff_of(op, amt);
        sa = a;
        case (op)
            2'b00:   r = sa >>> e;
            2'b01:   r = a >> e;
            2'b10:   r = a << e;
            default: r = (a >> e) | (a << (W - e));
        endcase
        return r;
    endfunction

    task automatic scramble();
        Op     = 2'($urandom_range(0, 3));
        Input1 = 8'($urandom);
        Input2 = 8'($urandom);
    endtask

    // Starts in an IDLE cycle (#1 after an edge); returns #1 after the edge
    // into the first IDLE cycle following completion.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input int lat, input bit spam);
        logic [W-1:0] prev;
        int c;
        bit seen;
        chk("idle_before", 32'(Busy), 32'd0);
        prev   = Result;
        Start  = 1'b1;
        Op     = op;
        Input1 = a;
        Input2 = b;
        @(posedge clk); #1;
        Start = spam;
        if (spam) scramble();
        c    = 1;
        seen = 1'b0;
        while (!seen && c <= W + 4) begin
            if (Done) begin
                seen = 1'b1;
            end else begin
                chk("busy_during", 32'(Busy), 32'd1);
                chk("result_hold", 32'(Result), 32'(prev));
                @(posedge clk); #1;
                if (spam) scramble();
                c++;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("done_latency", 32'(c), 32'(lat));
            chk("result", 32'(Result), 32'(res));
            chk("busy_at_done", 32'(Busy), 32'd1);
        end
        @(posedge clk); #1;
        Start = 1'b0;
        chk("busy_after", 32'(Busy), 32'd0);
        chk("done_after", 32'(Done), 32'd0);
        chk("result_kept", 32'(Result), 32'(res));
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst    = 1'b1;
        Start  = 1'b0;
        Op     = 2'b00;
        Input1 = '0;
        Input2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", 32'(Result), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_busy", 32'(Busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(2'b00, 8'h90, 8'd3,   8'hF2, 4, 1'b0);
        run_op(2'b01, 8'h90, 8'd3,   8'h12, 4, 1'b0);
        run_op(2'b10, 8'h81, 8'd1,   8'h02, 2, 1'b0);
        run_op(2'b11, 8'h81, 8'd9,   8'hC0, 2, 1'b0);
        run_op(2'b11, 8'h81, 8'd8,   8'h81, 1, 1'b0);
        run_op(2'b00, 8'h80, 8'hC8,  8'hFF, 9, 1'b0);
        run_op(2'b10, 8'h80, 8'hC8,  8'h00, 9, 1'b0);
        run_op(2'b00, 8'h7F, 8'd8,   8'h00, 9, 1'b0);
        run_op(2'b01, 8'hA5, 8'd0,   8'hA5, 1, 1'b0);

        // Start hammered during an op, then a back-to-back op
        run_op(2'b00, 8'h90, 8'd3,   8'hF2, 4, 1'b1);
        run_op(2'b01, 8'hF0, 8'd4,   8'h0F, 5, 1'b0);

        // Reset wins over Start in the same cycle
        rst    = 1'b1;
        Start  = 1'b1;
        Op     = 2'b01;
        Input1 = 8'hFF;
        Input2 = 8'd2;
        @(posedge clk); #1;
        rst   = 1'b0;
        Start = 1'b0;
        chk("rst_start_busy", 32'(Busy), 32'd0);
        chk("rst_start_result", 32'(Result), 32'd0);
        @(posedge clk); #1;
        chk("rst_start_still_idle", 32'(Busy), 32'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            run_op(rop, ra, rb, model(rop, ra, rb), 1 + eff_of(rop, rb), ($urandom_range(0, 4) == 0));
        end

        // Ensure a nonzero Result before the abort test
        run_op(2'b01, 8'h90, 8'd3, 8'h12, 4, 1'b0);

        // Reset in the second SHIFT cycle of an SRA-by-5
        Start  = 1'b1;
        Op     = 2'b00;
        Input1 = 8'hA5;
        Input2 = 8'd5;
        @(posedge clk); #1;
        Start = 1'b0;
        chk("abort_busy_shift1", 32'(Busy), 32'd1);
        @(posedge clk); #1;
        chk("abort_busy_shift2", 32'(Busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_result", 32'(Result), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("abort_no_done", 32'(Done), 32'd0);
            @(posedge clk); #1;
        end
        run_op(2'b00, 8'h90, 8'd3, 8'hF2, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Parametrised multi-cycle shift unit for the sequential datapath: accepts a signed operand, a shift amount and a 2-bit mode, then shifts one bit position per clock under an internal controller. It generalises the fixed 8-bit arithmetic-right-shift block to any power-of-two width and to four shift modes. It adds a Busy/Done handshake, amount saturation and a registered result.

## Interface
- `WIDTH`, 8: operand/result width; power of two, ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: shift-counter width (derived, not overridden).

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `Start`  in  1  request; sampled only in IDLE.
- `Op`  in  2  mode: 00 SRA, 01 SRL, 10 SLL, 11 ROR.
- `Input1`  in  WIDTH  operand to shift (two's complement for SRA).
- `Input2`  in  WIDTH  shift amount, interpreted unsigned.
- `Result`  out  WIDTH  registered result; holds the last completed value.
- `Done`  out  1  one-cycle completion pulse.
- `Busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with Start=1 at an edge:
  - load acc←Input1, op←Op, cnt←eff;
  - go to SHIFT if eff≠0, else go to DONE.
- Effective amount eff:
  - SRA/SRL/SLL: min(Input2, WIDTH);
  - ROR: Input2 mod WIDTH.
- SHIFT, each edge:
  - SRA: acc←{acc[MSB], acc[MSB:1]};
  - SRL: acc←{0, acc[MSB:1]};
  - SLL: acc←{acc[MSB-1:0], 0};
  - ROR: acc←{acc[0], acc[MSB:1]};
  - cnt←cnt−1;
  - when cnt==1 at the edge, go to DONE.
- Result register loads the final acc on the edge entering DONE.
- DONE: Done=1 for exactly that cycle; next edge returns to IDLE.
- Saturation: WIDTH steps of SRA give all sign bits; WIDTH steps of SRL/SLL give 0. No special-casing is needed beyond the clamp.
- Start while Busy (SHIFT or DONE) is ignored; no queuing. Operands only need to be valid in the Start cycle.
- Result is stable between completions. It never shows intermediate acc values.

## Timing
- Reset values: state IDLE, Result 0, Done 0, Busy 0, acc 0, cnt 0.
- rst has priority over every other input, including Start in the same cycle.
- Start accepted at edge N → Busy high from cycle N+1 → Done high in cycle N+1+eff → Busy low from cycle N+2+eff.
- eff=0: Done in cycle N+1 and Result=Input1.
- Worst case: Done in cycle N+1+WIDTH.
- Earliest next Start is accepted at edge N+2+eff, the first IDLE cycle. Throughput is one op per eff+2 cycles.
- rst mid-operation: next cycle is IDLE; Result←0; Done is never asserted for the aborted op.

## Structure
- Shared package `seq_shift_pkg` holds:
  - op localparams OP_SRA=2'b00, OP_SRL=2'b01, OP_SLL=2'b10, OP_ROR=2'b11;
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE.
- One natural sub-module: `shift_step`, the combinational single-position shifter (acc, op → next acc), parametrised by WIDTH.
- Controller FSM, counter and registers live in the top module. The controller is not split into a separate block.

## Test plan
- WIDTH=8, SRA, Input1=0x90, Input2=3 → Result=0xF2, Done in cycle N+4, Busy high in cycles N+1..N+4.
- SRL 0x90 by 3 → 0x12; SLL 0x81 by 1 → 0x02.
- ROR 0x81, Input2=9 → eff 1 → Result=0xC0, Done at N+2. Repeat with Input2=8 → Result=0x81, Done at N+1.
- SRA 0x80, Input2=0xC8 → clamped to 8 → 0xFF, Done at N+9. SLL same amount → 0x00.
- Start pulsed every cycle during an op, with different operands → ignored; Result from the first op only; the next op is accepted on the first IDLE cycle.
- rst asserted in the 2nd SHIFT cycle of an SRA-by-5 → IDLE next cycle, Result=0, Busy=0, no Done pulse. Then a clean op (SRA 0x90 by 3) completes with 0xF2.
